// File: rtl/alu_seq_unit.sv
// Handshaked 8-bit ALU: add/sub/mul are registered in one cycle, div/mod use 8-cycle restoring division.
// Optional define ALU_SEQ_ERR_EN adds err_o for divide-by-zero and reserved opcodes.
`timescale 1ns/1ps
module alu_seq_unit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] ctrl_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic [7:0] result_o
`ifdef ALU_SEQ_ERR_EN
    ,
    output logic       err_o
`endif
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [7:0] dvsr_q;
    logic [7:0] quot_q;
    logic [7:0] rem_q;
    logic [2:0] cnt_q;
    logic [7:0] result_q;

    logic [8:0] rem_sh;
    logic [8:0] rem_diff;
    logic       fits;
    logic [7:0] rem_nx;
    logic [7:0] quot_nx;
    logic       is_divmod;

    function automatic logic [7:0] fast_op(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [7:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign is_divmod = (ctrl_i == OP_DIV) || (ctrl_i == OP_MOD);

    // One restoring-division step: shift the next dividend bit into the partial remainder.
    // A zero divisor always "fits", which yields quotient FF and remainder equal to the dividend.
    always_comb begin
        rem_sh   = {rem_q, quot_q[7]};
        rem_diff = rem_sh - {1'b0, dvsr_q};
        fits     = (rem_sh >= {1'b0, dvsr_q});
        rem_nx   = fits ? rem_diff[7:0] : rem_sh[7:0];
        quot_nx  = {quot_q[6:0], fits};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = is_divmod ? DIV : DONE;
                end
            end
            DIV: begin
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= 3'd0;
            dvsr_q   <= 8'h00;
            quot_q   <= 8'h00;
            rem_q    <= 8'h00;
            cnt_q    <= 3'd0;
            result_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q   <= ctrl_i;
                        dvsr_q <= data1_i;
                        quot_q <= data0_i;
                        rem_q  <= 8'h00;
                        cnt_q  <= 3'd0;
                        if (!is_divmod) begin
                            result_q <= fast_op(ctrl_i, data0_i, data1_i);
                        end
                    end
                end
                DIV: begin
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_q <= (op_q == OP_DIV) ? quot_nx : rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ERR_EN
    logic err_q;

    // Error flag is written at the same points as result_q so both are valid together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid_i && !is_divmod) begin
                err_q <= (ctrl_i > OP_MOD);
            end else if (state_q == DIV && cnt_q == 3'd7) begin
                err_q <= (dvsr_q == 8'h00);
            end
        end
    end

    assign err_o = err_q;
`endif

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign result_o     = result_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus randomized ops against an arithmetic reference.
`timescale 1ns/1ps
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] ctrl = 3'd0;
    logic [7:0] d0 = 8'd0;
    logic [7:0] d1 = 8'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] result;
`ifdef ALU_SEQ_ERR_EN
    logic       err;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .ctrl_i      (ctrl),
        .data0_i     (d0),
        .data1_i     (d1),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .result_o    (result)
`ifdef ALU_SEQ_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_res(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = (a + b) & 255;
            1: r = (a - b) & 255;
            2: r = (a * b) & 255;
            3: r = (b == 0) ? 255 : a / b;
            4: r = (b == 0) ? a : a % b;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic ref_err(input int op, input int b);
        return ((op == 3 || op == 4) && b == 0) || (op > 4);
    endfunction

    function automatic int ref_lat(input int op);
        return (op == 3 || op == 4) ? 9 : 1;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input string tag);
        int lat;
        logic [7:0] held;
        @(negedge clk);
        chk({tag, ":req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        ctrl = op;
        d0 = a;
        d1 = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ctrl = 3'($urandom);
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        chk({tag, ":latency"}, lat, ref_lat(op));
        chk({tag, ":result"}, result, ref_res(op, a, b));
`ifdef ALU_SEQ_ERR_EN
        chk({tag, ":err"}, err, ref_err(op, b));
`endif
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, resp_valid, 1);
            chk({tag, ":hold_result"}, result, held);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ":released"}, resp_valid, 0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        int seen;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset:req_ready", req_ready, 1);
        chk("reset:resp_valid", resp_valid, 0);
        chk("reset:result", result, 0);

        run_op(3'd0, 8'd200, 8'd100, 0, "add");
        run_op(3'd1, 8'd5, 8'd10, 1, "sub");
        run_op(3'd2, 8'd15, 8'd20, 0, "mul");
        run_op(3'd3, 8'd200, 8'd7, 0, "div");
        run_op(3'd4, 8'd200, 8'd7, 2, "mod");
        run_op(3'd3, 8'd37, 8'd0, 0, "div0");
        run_op(3'd4, 8'd37, 8'd0, 0, "mod0");
        run_op(3'd6, 8'd37, 8'd5, 0, "reserved");

        // Mid-simulation reset with a nonzero result held.
        run_op(3'd0, 8'd200, 8'd100, 0, "pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset:req_ready", req_ready, 1);
        chk("midreset:resp_valid", resp_valid, 0);
        chk("midreset:result", result, 0);

        // Backpressure: response held while new requests hammer the input.
        @(negedge clk);
        req_valid = 1'b1;
        ctrl = 3'd0;
        d0 = 8'd200;
        d1 = 8'd100;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            ctrl = 3'($urandom);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            @(negedge clk);
            chk("bp:valid", resp_valid, 1);
            chk("bp:result", result, 8'd44);
            chk("bp:req_ready", req_ready, 0);
        end
        ctrl = 3'd0;
        d0 = 8'd9;
        d1 = 8'd4;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp:req_ready_after", req_ready, 1);
        chk("bp:valid_after", resp_valid, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp:next_valid", resp_valid, 1);
        chk("bp:next_result", result, 8'd13);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // Reset during the fourth division cycle discards the operation.
        @(negedge clk);
        req_valid = 1'b1;
        ctrl = 3'd3;
        d0 = 8'd200;
        d1 = 8'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("divreset:no_resp", seen, 0);
        chk("divreset:req_ready", req_ready, 1);
        run_op(3'd0, 8'd1, 8'd2, 0, "post_reset_add");

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(rop, ra, rb, $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
